// File: rtl/cluster_pe_nd.sv
// k-d-tree cluster processing element: holds one centre, accumulates assigned
// points, swaps centres with neighbours and recomputes the floor-mean centre.
module cluster_pe_nd #(
   parameter int DIM         = 3,
   parameter int DIM_SIZE    = 8,
   parameter int MAX_N       = 1024,
   parameter int MAX_DEPTH   = 16,
   parameter logic [DIM*DIM_SIZE-1:0] INITIAL_CENTER = '0,
   localparam int CENTER_SIZE = DIM*DIM_SIZE,
   localparam int CNT_W       = $clog2(MAX_N+1),
   localparam int ACC_W       = DIM_SIZE+CNT_W,
   localparam int DEPTH_W     = $clog2(MAX_DEPTH+1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   point_valid,
   output logic                   point_ready,
   input  logic [CENTER_SIZE-1:0] point_in,
   input  logic                   inc,
   input  logic                   parent_switch,
   input  logic                   child_switch,
   input  logic [CENTER_SIZE-1:0] parent_in,
   input  logic [CENTER_SIZE-1:0] child_in,
   output logic [CENTER_SIZE-1:0] parent_out,
   output logic [CENTER_SIZE-1:0] child_out,
   input  logic [DEPTH_W-1:0]     depth,
   input  logic                   next_level,
   output logic [DEPTH_W-1:0]     child_depth,
   input  logic                   update_start,
   output logic                   update_done,
   output logic                   busy,
   output logic                   stable,
   output logic                   overflow,
   output logic [CENTER_SIZE-1:0] center_out,
   output logic [CNT_W-1:0]       count_out
);

   localparam int DIDX_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int BIT_W  = $clog2(ACC_W);

   typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

   state_t                 state, state_next;
   logic [ACC_W-1:0]       acc [DIM];
   logic [CNT_W-1:0]       count;
   logic [CENTER_SIZE-1:0] point;
   logic [CENTER_SIZE-1:0] old_center;
   logic [CENTER_SIZE-1:0] shadow;
   logic [CENTER_SIZE-1:0] new_center;
   logic [DEPTH_W-1:0]     ttl;
   logic [DIDX_W-1:0]      dcnt;
   logic [BIT_W-1:0]       bcnt;
   logic [CNT_W-1:0]       rem;
   logic [DIM_SIZE-1:0]    quot;
   logic [DIM_SIZE-1:0]    quot_next;
   logic [CNT_W:0]         rem_sh;
   logic [CNT_W:0]         rem_sub;
   logic                   q_bit;
   logic                   switch_en;
   logic                   last_bit;
   logic                   last_dim;

   assign point_ready = en && (state == IDLE);
   assign busy        = (state == UPDATE);
   assign center_out  = old_center;
   assign count_out   = count;
   assign switch_en   = (ttl != '0);
   assign last_bit    = (bcnt == '0);
   assign last_dim    = (dcnt == DIDX_W'(DIM-1));
   assign child_depth = (depth >= DEPTH_W'(MAX_DEPTH)) ? DEPTH_W'(MAX_DEPTH) : depth + DEPTH_W'(1);
   // An empty cluster keeps its centre, which also makes it report stable.
   assign new_center  = (count == '0) ? old_center : shadow;

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_sh    = {rem, acc[dcnt][bcnt]};
      q_bit     = (rem_sh >= {1'b0, count});
      rem_sub   = q_bit ? (rem_sh - {1'b0, count}) : rem_sh;
      quot_next = {quot[DIM_SIZE-2:0], q_bit};
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (update_start) state_next = (count != '0) ? UPDATE : DONE;
         UPDATE:  if (last_bit && last_dim) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else if (en) state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst) update_done <= 1'b0;
      else      update_done <= en && (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int d = 0; d < DIM; d++) acc[d] <= '0;
         count      <= '0;
         point      <= '0;
         old_center <= INITIAL_CENTER;
         parent_out <= '0;
         child_out  <= '0;
         ttl        <= depth;
         stable     <= 1'b0;
         overflow   <= 1'b0;
      end else if (en) begin
         if (next_level && switch_en) ttl <= ttl - DEPTH_W'(1);
         case (state)
            IDLE: begin
               if (point_valid) point <= point_in;
               if (inc) begin
                  if (count == CNT_W'(MAX_N)) begin
                     overflow <= 1'b1;
                  end else begin
                     for (int d = 0; d < DIM; d++)
                        acc[d] <= acc[d] + ACC_W'(point[d*DIM_SIZE +: DIM_SIZE]);
                     count <= count + CNT_W'(1);
                  end
               end
               if (switch_en && parent_switch) begin
                  parent_out <= old_center;
                  old_center <= parent_in;
               end else if (switch_en && child_switch) begin
                  child_out  <= old_center;
                  old_center <= child_in;
               end
            end
            DONE: begin
               stable     <= (new_center == old_center);
               old_center <= new_center;
               for (int d = 0; d < DIM; d++) acc[d] <= '0;
               count      <= '0;
               overflow   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Divider sequencing; shadow only reaches old_center through DONE, so an
   // aborted division never leaves a partial centre behind.
   always_ff @(posedge clk) begin
      if (en) begin
         if (state == IDLE && update_start) begin
            dcnt <= '0;
            bcnt <= BIT_W'(ACC_W-1);
            rem  <= '0;
            quot <= '0;
         end else if (state == UPDATE) begin
            if (last_bit) begin
               shadow[dcnt*DIM_SIZE +: DIM_SIZE] <= quot_next;
               rem  <= '0;
               quot <= '0;
               bcnt <= BIT_W'(ACC_W-1);
               dcnt <= dcnt + DIDX_W'(1);
            end else begin
               rem  <= rem_sub[CNT_W-1:0];
               quot <= quot_next;
               bcnt <= bcnt - BIT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/cluster_pe_nd.md
Name: cluster_pe_nd

Overview:
- Parametrised next-generation k-d-tree cluster processing element for the k-means engine.
- Holds one cluster centre of DIM dimensions and accepts points over a valid/ready handshake.
- Accumulates per-dimension sums and a point count, and swaps centres with its parent or child node under time-to-live control.
- On request, computes the new centre as the floor mean using a sequential divider, then reports whether the centre has converged (stable).

Parameters:
- DIM, 3: number of dimensions.
- DIM_SIZE, 8: bits per coordinate.
- MAX_N, 1024: maximum number of points accumulated per iteration.
- MAX_DEPTH, 16: maximum tree depth.
- INITIAL_CENTER, 0: centre value loaded at reset (CENTER_SIZE bits).
- Derived values:
  - CENTER_SIZE = DIM*DIM_SIZE
  - CNT_W = $clog2(MAX_N+1)
  - ACC_W = DIM_SIZE+CNT_W
  - DEPTH_W = $clog2(MAX_DEPTH+1)

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  global enable; when low, all state holds.
- point_valid  in  1  point_in is valid.
- point_ready  out  1  combinational: en && state==IDLE.
- point_in  in  CENTER_SIZE  incoming point; dimension d sits at [d*DIM_SIZE +: DIM_SIZE].
- inc  in  1  add the registered point to the accumulators.
- parent_switch  in  1  swap centre with the parent node.
- child_switch  in  1  swap centre with the child node.
- parent_in  in  CENTER_SIZE  centre arriving from the parent.
- child_in  in  CENTER_SIZE  centre arriving from the child.
- parent_out  out  CENTER_SIZE  registered centre sent to the parent.
- child_out  out  CENTER_SIZE  registered centre sent to the child.
- depth  in  DEPTH_W  depth of this node.
- next_level  in  1  decrement time_to_live.
- child_depth  out  DEPTH_W  min(depth+1, MAX_DEPTH), combinational.
- update_start  in  1  begin the mean computation.
- update_done  out  1  one-cycle pulse when the new centre is committed.
- busy  out  1  high while in state UPDATE.
- stable  out  1  the last update left the centre unchanged.
- overflow  out  1  sticky flag: an inc was dropped because the count was saturated.
- center_out  out  CENTER_SIZE  current centre (old_center).
- count_out  out  CNT_W  current point count.

Behaviour:
- Reset (rst==0 at an edge):
  - Register values: acc[*]=0, count=0, point=0, old_center=INITIAL_CENTER, parent_out=0, child_out=0, time_to_live=depth, stable=0, overflow=0, update_done=0, state=IDLE.
  - Reset mid-UPDATE aborts the division with no partial commit.
- When en==0, every register holds and update_done is forced to 0.
- States and transitions:
  - IDLE -> UPDATE on update_start with count!=0.
  - UPDATE -> DONE after DIM*ACC_W step cycles.
  - DONE -> IDLE unconditionally.
  - IDLE -> DONE directly on update_start with count==0.
- Point capture:
  - On point_valid && point_ready: point <= point_in.
  - Nothing is captured outside IDLE.
- inc (IDLE only):
  - acc[d] <= acc[d] + point[d] for every d; count <= count+1.
  - Uses the point value registered before this edge, so a capture and an inc on the same edge adds the old point.
  - If count==MAX_N: the inc is dropped and overflow <= 1.
- Time to live:
  - switch_en = (time_to_live != 0).
  - next_level: time_to_live <= time_to_live-1, saturating at 0.
  - next_level and a switch may occur on the same edge; the switch uses the pre-decrement time_to_live.
- Centre swaps (IDLE only, requires switch_en):
  - parent_switch: parent_out <= old_center; old_center <= parent_in.
  - child_switch: child_out <= old_center; old_center <= child_in.
  - If both are asserted, parent_switch has priority and child_switch is ignored.
  - Outputs capture the pre-swap centre (nonblocking semantics).
  - Swaps are ignored when time_to_live==0.
- UPDATE:
  - Restoring division of acc[d] by count, dimension 0 first, ACC_W cycles per dimension.
  - Quotients are written to a shadow register.
  - Floor mean is always <= 2^DIM_SIZE-1; the truncated quotient is used.
  - inc, point capture, swaps and update_start are all ignored while in UPDATE.
- DONE (one cycle):
  - stable <= (shadow == old_center); old_center <= shadow.
  - acc[*], count and overflow are cleared to 0.
  - update_done = 1.
  - When count==0: shadow = old_center, so stable <= 1 and the centre is unchanged.
- update_done latency, counted from the edge that samples update_start:
  - count==0: update_done is high in the following cycle (1 cycle).
  - Otherwise: DIM*ACC_W+1 cycles, which is 58 at the defaults.

Test Plan:
- Reset and swap:
  - Reset with INITIAL_CENTER=[10,20,30], depth=2, then parent_switch with parent_in=[1,2,3].
  - Required: parent_out=[10,20,30] and center_out=[1,2,3] after one edge.
- Time to live:
  - depth=1; next_level; then child_switch.
  - Required: the switch is ignored, child_out stays 0, center_out is unchanged.
  - Assert next_level again: time_to_live stays 0.
- Mean update:
  - Push points [2,4,6], [4,8,10] and [6,9,14], each with inc, then update_start.
  - Required: busy for 57 cycles, update_done pulse at cycle 58, center_out=[4,7,10], stable=0, count_out=0.
- Convergence:
  - Repeat with three points each equal to [4,7,10].
  - Required: center_out=[4,7,10] and stable=1.
- Empty update:
  - update_start with count 0.
  - Required: update_done one cycle later, stable=1, centre unchanged.
- Saturation, priority and reset abort (MAX_N=4):
  - Five incs: count_out=4 and overflow=1.
  - parent_switch and child_switch together: only the parent swap occurs.
  - rst=0 at cycle 10 of UPDATE: all values return to reset, no update_done.
